// File: rtl/snn_pkg.sv
// Shared SNN definitions: encoder FSM states and the default image/timestep geometry
// reused by the AXI slave, the spike encoder and the SNN core.
package snn_pkg;

  localparam int unsigned DEFAULT_IMAGE_SIZE = 256;
  localparam int unsigned DEFAULT_PIXEL_BITS = 8;
  localparam int unsigned DEFAULT_NUM_STEPS  = 16;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EMIT,
    TICK,
    DONE
  } enc_state_t;

endpackage

// File: rtl/rate_acc_bank.sv
// Per-pixel phase accumulators: synchronous clear-all plus a single read-modify-write
// port whose carry-out marks a spike for the addressed pixel.
module rate_acc_bank
  import snn_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE      = DEFAULT_IMAGE_SIZE,
  parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int unsigned PIXEL_BITS      = DEFAULT_PIXEL_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic [IMAGE_SIZE_BITS-1:0] idx,
  input  logic [PIXEL_BITS-1:0]      pixel,
  output logic                       carry
);

  logic [PIXEL_BITS-1:0] acc [IMAGE_SIZE];
  logic [PIXEL_BITS:0]   sum;

  assign sum   = {1'b0, acc[idx]} + {1'b0, pixel};
  assign carry = sum[PIXEL_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '{default: '0};
    end else if (clr) begin
      acc <= '{default: '0};
    end else if (en) begin
      acc[idx] <= sum[PIXEL_BITS-1:0];
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes a live pixel image into an AER spike/tick stream over NUM_STEPS timesteps
// using per-pixel phase accumulators; events leave over a valid/ready handshake.
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE      = DEFAULT_IMAGE_SIZE,
  parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int unsigned PIXEL_BITS      = DEFAULT_PIXEL_BITS,
  parameter int unsigned NUM_STEPS       = DEFAULT_NUM_STEPS,
  parameter int unsigned STEP_BITS       = $clog2(NUM_STEPS + 1)
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETN,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  input  logic                                  NEW_IMAGE,
  output logic                                  SPIKE_VALID,
  input  logic                                  SPIKE_READY,
  output logic [IMAGE_SIZE_BITS-1:0]            SPIKE_ADDR,
  output logic                                  SPIKE_TICK,
  output logic                                  ENC_BUSY,
  output logic                                  ENC_DONE
);

  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX  = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [STEP_BITS-1:0]       LAST_STEP = STEP_BITS'(NUM_STEPS - 1);

  enc_state_t                 state, state_d;
  logic [IMAGE_SIZE_BITS-1:0] idx, idx_d;
  logic [STEP_BITS-1:0]       step, step_d;
  logic                       valid, valid_d;
  logic [IMAGE_SIZE_BITS-1:0] addr, addr_d;
  logic                       tick, tick_d;
  logic                       busy, busy_d;
  logic                       done, done_d;
  logic                       new_image_q;
  logic                       edge_armed;
  logic                       start;
  logic                       handshake;
  logic                       last_pixel;
  logic                       last_step;
  logic                       acc_clr;
  logic                       acc_en;
  logic                       carry;

  rate_acc_bank #(
    .IMAGE_SIZE      (IMAGE_SIZE),
    .IMAGE_SIZE_BITS (IMAGE_SIZE_BITS),
    .PIXEL_BITS      (PIXEL_BITS)
  ) u_acc_bank (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .clr   (acc_clr),
    .en    (acc_en),
    .idx   (idx),
    .pixel (IMAGE[idx]),
    .carry (carry)
  );

  // edge_armed requires NEW_IMAGE to be seen low after reset, so a level held
  // high across reset release is not mistaken for a fresh rising edge.
  assign start      = NEW_IMAGE & ~new_image_q & edge_armed;
  assign handshake  = valid & SPIKE_READY;
  assign last_pixel = (idx == LAST_IDX);
  assign last_step  = (step == LAST_STEP);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      new_image_q <= 1'b0;
      edge_armed  <= 1'b0;
    end else begin
      new_image_q <= NEW_IMAGE;
      if (!NEW_IMAGE) edge_armed <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      idx   <= '0;
      step  <= '0;
      valid <= 1'b0;
      addr  <= '0;
      tick  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      step  <= step_d;
      valid <= valid_d;
      addr  <= addr_d;
      tick  <= tick_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Tick outputs are loaded on entry to TICK, so the marker is presented in the first TICK cycle.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    step_d  = step;
    valid_d = valid;
    addr_d  = addr;
    tick_d  = tick;
    busy_d  = busy;
    done_d  = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clr = 1'b1;
          idx_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_en = 1'b1;
        if (carry) begin
          valid_d = 1'b1;
          addr_d  = idx;
          tick_d  = 1'b0;
          state_d = EMIT;
        end else if (!last_pixel) begin
          idx_d = idx + 1'b1;
        end else begin
          valid_d = 1'b1;
          addr_d  = '0;
          tick_d  = 1'b1;
          state_d = TICK;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (last_pixel) begin
            addr_d  = '0;
            tick_d  = 1'b1;
            state_d = TICK;
          end else begin
            valid_d = 1'b0;
            idx_d   = idx + 1'b1;
            state_d = SCAN;
          end
        end
      end
      TICK: begin
        if (handshake) begin
          valid_d = 1'b0;
          tick_d  = 1'b0;
          step_d  = step + 1'b1;
          idx_d   = '0;
          if (last_step) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SPIKE_VALID = valid;
  assign SPIKE_ADDR  = addr;
  assign SPIKE_TICK  = tick;
  assign ENC_BUSY    = busy;
  assign ENC_DONE    = done;

endmodule
